// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - two-requester 32-bit to 16-bit asynchronous SRAM bridge
//
// Arbitrates between the instruction-fetch port (read only) and the data
// port (read/write). mem_req has fixed priority over if_req. Each 32-bit
// word is moved as two 16-bit SRAM phases, low halfword first. Each phase
// lasts WAIT_CYCLES+1 clocks.
//
// Ports:
//   clock, reset             system clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request and word address
//   if_rdata/if_ack          fetch read data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr  data request, write flag and word address
//   mem_wdata                data write word
//   mem_rdata/mem_ack        data read data and one-cycle completion pulse
//   sram_addr                SRAM halfword address
//   sram_dq                  shared tri-state SRAM data bus
//   sram_we_n/oe_n/ce_n      SRAM strobes, active-low
//   sram_ub_n/lb_n           SRAM byte masks, active-low
module sram_bridge #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [16:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [16:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic [17:0] sram_addr,
   inout  wire  [15:0] sram_dq,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_ce_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          grant_mem;
   logic [16:0]   addr_l;
   logic [15:0]   wdata_hi;
   logic [15:0]   lo_buf;
   logic [15:0]   dq_out;
   logic          dq_oe;

   // The bus is only ever driven from a registered enable, so it can never
   // overlap a cycle where oe_n is low.
   assign sram_dq = dq_oe ? dq_out : 16'hzzzz;
   assign cnt_nxt = cnt + 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         grant_mem <= 1'b0;
         addr_l    <= '0;
         wdata_hi  <= '0;
         lo_buf    <= '0;
         dq_out    <= '0;
         dq_oe     <= 1'b0;
         if_rdata  <= '0;
         if_ack    <= 1'b0;
         mem_rdata <= '0;
         mem_ack   <= 1'b0;
         sram_addr <= '0;
         sram_we_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_ce_n <= 1'b1;
         sram_ub_n <= 1'b1;
         sram_lb_n <= 1'b1;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req || if_req) begin
                  grant_mem <= mem_req;
                  addr_l    <= mem_req ? mem_addr : if_addr;
                  wdata_hi  <= mem_wdata[31:16];
                  cnt       <= '0;
                  sram_addr <= {(mem_req ? mem_addr : if_addr), 1'b0};
                  sram_ce_n <= 1'b0;
                  sram_ub_n <= 1'b0;
                  sram_lb_n <= 1'b0;
                  if (mem_req && mem_we) begin
                     state     <= WR_LO;
                     sram_oe_n <= 1'b1;
                     sram_we_n <= 1'b0;
                     dq_oe     <= 1'b1;
                     dq_out    <= mem_wdata[15:0];
                  end else begin
                     state     <= RD_LO;
                     sram_oe_n <= 1'b0;
                     sram_we_n <= 1'b1;
                     dq_oe     <= 1'b0;
                  end
               end
            end

            RD_LO, RD_HI: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (state == RD_LO) begin
                     // Capture on the edge that closes the phase.
                     lo_buf    <= sram_dq;
                     sram_addr <= {addr_l, 1'b1};
                     state     <= RD_HI;
                  end else begin
                     state     <= DONE;
                     sram_ce_n <= 1'b1;
                     sram_oe_n <= 1'b1;
                     sram_ub_n <= 1'b1;
                     sram_lb_n <= 1'b1;
                     if (grant_mem) begin
                        mem_rdata <= {sram_dq, lo_buf};
                        mem_ack   <= 1'b1;
                     end else begin
                        if_rdata  <= {sram_dq, lo_buf};
                        if_ack    <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt_nxt;
               end
            end

            WR_LO, WR_HI: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (state == WR_LO) begin
                     sram_addr <= {addr_l, 1'b1};
                     sram_we_n <= 1'b0;
                     dq_out    <= wdata_hi;
                     state     <= WR_HI;
                  end else begin
                     state     <= DONE;
                     sram_ce_n <= 1'b1;
                     sram_we_n <= 1'b1;
                     sram_ub_n <= 1'b1;
                     sram_lb_n <= 1'b1;
                     dq_oe     <= 1'b0;
                     mem_ack   <= 1'b1;
                  end
               end else begin
                  cnt       <= cnt_nxt;
                  // Raise we_n for the final cycle so data is held past the strobe.
                  sram_we_n <= (cnt_nxt == LAST);
               end
            end

            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bridge.sv
// tb/tb_sram_bridge.sv - randomized self-checking bench for sram_bridge
module tb_sram_bridge;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        if_req    [2];
   logic [16:0] if_addr   [2];
   wire  [31:0] if_rdata  [2];
   wire         if_ack    [2];
   logic        mem_req   [2];
   logic        mem_we    [2];
   logic [16:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   wire  [31:0] mem_rdata [2];
   wire         mem_ack   [2];
   wire  [17:0] s_addr    [2];
   wire         we_n      [2];
   wire         oe_n      [2];
   wire         ce_n      [2];
   wire         ub_n      [2];
   wire         lb_n      [2];
   wire  [15:0] dq0;
   wire  [15:0] dq1;

   int errors = 0;
   int checks = 0;

   sram_bridge #(.WAIT_CYCLES(1)) u_dut0 (
      .clock(clock), .reset(reset),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
      .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]),
      .sram_addr(s_addr[0]), .sram_dq(dq0), .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]),
      .sram_ce_n(ce_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
   );

   sram_bridge #(.WAIT_CYCLES(3)) u_dut1 (
      .clock(clock), .reset(reset),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
      .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]),
      .sram_addr(s_addr[1]), .sram_dq(dq1), .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]),
      .sram_ce_n(ce_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
   );

   // SRAM array per DUT; written only by the negedge process below
   logic [15:0] sram_mem [2][262144];
   logic        ld_en = 1'b0;
   int          ld_k  = 0;
   logic [17:0] ld_a  = '0;
   logic [15:0] ld_d  = '0;

   assign dq0 = (!ce_n[0] && !oe_n[0]) ? sram_mem[0][s_addr[0]] : 16'hzzzz;
   assign dq1 = (!ce_n[1] && !oe_n[1]) ? sram_mem[1][s_addr[1]] : 16'hzzzz;

   // Bus monitor counters (monotonic; the stimulus thread diffs snapshots)
   logic [16:0] exp_a [2];
   int ce_cnt [2] = '{0, 0};
   int oe_cnt [2] = '{0, 0};
   int we_cnt [2] = '{0, 0};
   int bad_cnt[2] = '{0, 0};
   int pos    [2] = '{0, 0};
   int ia_cnt [2] = '{0, 0};
   int ma_cnt [2] = '{0, 0};

   // Reference SRAM contents as seen by the requesters
   logic [15:0] model [int];

   function automatic int plen(int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic int mkey(int k, logic [17:0] a);
      return k * 262144 + int'(a);
   endfunction

   function automatic logic [15:0] mget(int k, logic [17:0] a);
      return model.exists(mkey(k, a)) ? model[mkey(k, a)] : 16'h0000;
   endfunction

   always @(negedge clock) begin
      if (ld_en) sram_mem[ld_k][ld_a] <= ld_d;
      for (int k = 0; k < 2; k++) begin
         if (!ce_n[k]) begin
            ce_cnt[k] <= ce_cnt[k] + 1;
            pos[k]    <= pos[k] + 1;
            if (!oe_n[k]) oe_cnt[k] <= oe_cnt[k] + 1;
            if (!we_n[k]) begin
               we_cnt[k] <= we_cnt[k] + 1;
               sram_mem[k][s_addr[k]] <= (k == 0) ? dq0 : dq1;
            end
            if (s_addr[k] != {exp_a[k], (pos[k] >= plen(k))} || ub_n[k] || lb_n[k] ||
                (!oe_n[k] && !we_n[k]) || pos[k] >= 2 * plen(k))
               bad_cnt[k] <= bad_cnt[k] + 1;
         end else begin
            pos[k] <= 0;
            if (!oe_n[k] || !we_n[k]) bad_cnt[k] <= bad_cnt[k] + 1;
         end
         if (if_ack[k])  ia_cnt[k] <= ia_cnt[k] + 1;
         if (mem_ack[k]) ma_cnt[k] <= ma_cnt[k] + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic preload(input int k, input logic [17:0] a, input logic [15:0] d);
      ld_k = k; ld_a = a; ld_d = d; ld_en = 1'b1;
      @(negedge clock);
      #1 ld_en = 1'b0;
      model[mkey(k, a)] = d;
   endtask

   task automatic check_idle(input int k, input string tag);
      check_eq($sformatf("%s_strobes%0d", tag, k),
               {we_n[k], oe_n[k], ce_n[k], ub_n[k], lb_n[k]}, 5'b11111);
      check_eq($sformatf("%s_acks%0d", tag, k), {if_ack[k], mem_ack[k]}, 2'b00);
      check_eq($sformatf("%s_addr%0d", tag, k), s_addr[k], 18'h0);
      check_eq($sformatf("%s_mrdata%0d", tag, k), mem_rdata[k], 32'h0);
   endtask

   task automatic txn(input int k, input bit is_mem, input bit we,
                      input logic [16:0] a, input logic [31:0] wd);
      int p, c, ce0, oe0, we0, bad0, ia0, ma0;
      bit got;
      bit wr;
      logic [31:0] exp;
      p  = plen(k);
      wr = is_mem && we;
      @(posedge clock); #1;
      exp_a[k] = a;
      ce0 = ce_cnt[k]; oe0 = oe_cnt[k]; we0 = we_cnt[k];
      bad0 = bad_cnt[k]; ia0 = ia_cnt[k]; ma0 = ma_cnt[k];
      if (is_mem) begin
         mem_req[k] = 1'b1; mem_we[k] = we; mem_addr[k] = a; mem_wdata[k] = wd;
      end else begin
         if_req[k] = 1'b1; if_addr[k] = a;
      end
      exp = '0;
      if (wr) begin
         model[mkey(k, {a, 1'b0})] = wd[15:0];
         model[mkey(k, {a, 1'b1})] = wd[31:16];
      end else begin
         exp = {mget(k, {a, 1'b1}), mget(k, {a, 1'b0})};
      end
      c = 0; got = 1'b0;
      while (c < 40 && !got) begin
         @(posedge clock); #1;
         c++;
         got = is_mem ? mem_ack[k] : if_ack[k];
         if (c == 2) begin
            // inputs after grant must be ignored
            mem_addr[k] = 17'($urandom); mem_wdata[k] = $urandom;
            mem_we[k] = 1'($urandom); if_addr[k] = 17'($urandom);
         end
      end
      check_eq($sformatf("latency%0d", k), c, 2 * p + 1);
      check_eq($sformatf("other_ack%0d", k), is_mem ? if_ack[k] : mem_ack[k], 1'b0);
      if (!wr) check_eq($sformatf("rdata%0d", k), is_mem ? mem_rdata[k] : if_rdata[k], exp);
      if_req[k] = 1'b0; mem_req[k] = 1'b0; mem_we[k] = 1'b0;
      @(posedge clock); #1;
      check_eq($sformatf("ack_pulse%0d", k), {if_ack[k], mem_ack[k]}, 2'b00);
      if (!wr) check_eq($sformatf("rdata_hold%0d", k), is_mem ? mem_rdata[k] : if_rdata[k], exp);
      check_eq($sformatf("ce_cycles%0d", k), ce_cnt[k] - ce0, 2 * p);
      check_eq($sformatf("oe_cycles%0d", k), oe_cnt[k] - oe0, wr ? 0 : 2 * p);
      check_eq($sformatf("we_cycles%0d", k), we_cnt[k] - we0, wr ? 2 * (p - 1) : 0);
      check_eq($sformatf("bus_rules%0d", k), bad_cnt[k] - bad0, 0);
      check_eq($sformatf("ack_count%0d", k), {ia_cnt[k] - ia0, ma_cnt[k] - ma0},
               is_mem ? {32'd0, 32'd1} : {32'd1, 32'd0});
      if (wr) begin
         check_eq($sformatf("sram_lo%0d", k), sram_mem[k][{a, 1'b0}], wd[15:0]);
         check_eq($sformatf("sram_hi%0d", k), sram_mem[k][{a, 1'b1}], wd[31:16]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [16:0] pool [8];
      logic [31:0] wd;
      int c, cm, ci, ma0, ia0, bad0;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 0; if_addr[k] = 0; mem_req[k] = 0; mem_we[k] = 0;
         mem_addr[k] = 0; mem_wdata[k] = 0; exp_a[k] = 0;
      end
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         check_idle(k, "reset");
         check_eq($sformatf("reset_irdata%0d", k), if_rdata[k], 32'h0);
      end
      reset = 1'b1;

      // Directed: fetch of preloaded word
      preload(0, 18'h00010, 16'hBEEF);
      preload(0, 18'h00011, 16'hDEAD);
      txn(0, 1'b0, 1'b0, 17'h00008, 32'h0);
      check_eq("fetch_word", if_rdata[0], 32'hDEADBEEF);

      // Directed: write to top address and read it back
      txn(0, 1'b1, 1'b1, 17'h1FFFF, 32'h12345678);
      txn(0, 1'b1, 1'b0, 17'h1FFFF, 32'h0);
      check_eq("readback_top", mem_rdata[0], 32'h12345678);

      // Simultaneous requests: mem first, fetch in the following transaction
      @(posedge clock); #1;
      ma0 = ma_cnt[0]; ia0 = ia_cnt[0]; bad0 = bad_cnt[0];
      exp_a[0] = 17'h00123;
      mem_req[0] = 1; mem_we[0] = 1; mem_addr[0] = 17'h00123; mem_wdata[0] = 32'hCAFE0001;
      if_req[0] = 1; if_addr[0] = 17'h00008;
      model[mkey(0, 18'h00246)] = 16'h0001;
      model[mkey(0, 18'h00247)] = 16'hCAFE;
      c = 0; cm = -1; ci = -1;
      while (c < 40 && ci < 0) begin
         @(posedge clock); #1;
         c++;
         if (mem_ack[0]) begin cm = c; mem_req[0] = 0; mem_we[0] = 0; exp_a[0] = 17'h00008; end
         if (if_ack[0]) begin
            ci = c; if_req[0] = 0;
            check_eq("arb_if_rdata", if_rdata[0], {mget(0, 18'h00011), mget(0, 18'h00010)});
         end
      end
      check_eq("arb_mem_first", cm, 5);
      check_eq("arb_if_second", ci, 11);
      @(posedge clock); #1;
      check_eq("arb_acks", {ma_cnt[0] - ma0, ia_cnt[0] - ia0}, {32'd1, 32'd1});
      check_eq("arb_bus_rules", bad_cnt[0] - bad0, 0);
      check_eq("arb_sram", {sram_mem[0][18'h00247], sram_mem[0][18'h00246]}, 32'hCAFE0001);

      // Reset during WR_HI
      @(posedge clock); #1;
      wd = $urandom;
      ma0 = ma_cnt[0];
      exp_a[0] = 17'h00777;
      mem_req[0] = 1; mem_we[0] = 1; mem_addr[0] = 17'h00777; mem_wdata[0] = wd;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      mem_req[0] = 0; mem_we[0] = 0;
      #1;
      check_idle(0, "midreset");
      repeat (2) @(posedge clock);
      #3 reset = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      check_eq("midreset_no_ack", ma_cnt[0] - ma0, 0);
      check_eq("midreset_lo", sram_mem[0][18'h00EEE], wd[15:0]);
      check_eq("midreset_hi", sram_mem[0][18'h00EEF], mget(0, 18'h00EEF));
      model[mkey(0, 18'h00EEE)] = wd[15:0];
      txn(0, 1'b1, 1'b0, 17'h00777, 32'h0);

      // Randomized traffic on both wait settings
      for (int k = 0; k < 2; k++) begin
         pool[0] = 17'h00000;
         pool[1] = 17'h1FFFF;
         for (int i = 2; i < 8; i++) pool[i] = 17'($urandom);
         for (int i = 0; i < 40; i++) begin
            bit is_mem;
            is_mem = 1'($urandom);
            txn(k, is_mem, is_mem && (i < 8 || $urandom_range(1, 0) == 1),
                pool[$urandom_range(7, 0)], $urandom);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
